// File: rtl/nco_cmd_sequencer_pkg.sv
// Shared types for the NCO command sequencer: opcodes, FSM states, buffered command record.
package nco_pkg;

  localparam int CMD_N       = 22;
  localparam int CMD_Z_W     = 12;
  localparam int CMD_DUR_W   = 16;
  localparam int PHASE_WIDTH = 24;

  typedef enum logic [1:0] {
    OP_SET_FTW = 2'd0,
    OP_VZ      = 2'd1,
    OP_RUN     = 2'd2,
    OP_HOLD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FTW      = 3'd1,
    ST_VZ_LOAD  = 3'd2,
    ST_VZ_APPLY = 3'd3,
    ST_RUN      = 3'd4,
    ST_HOLD     = 3'd5
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [CMD_N-1:0]     data;
    logic [CMD_DUR_W-1:0] dur;
  } cmd_t;

  // Cycles remaining after the first one; a zero duration behaves like one.
  function automatic logic [CMD_DUR_W-1:0] dur_last(input logic [CMD_DUR_W-1:0] dur);
    return (dur == '0) ? '0 : dur - CMD_DUR_W'(1);
  endfunction

  function automatic state_e op_to_state(input op_e op);
    case (op)
      OP_SET_FTW: return ST_FTW;
      OP_VZ:      return ST_VZ_LOAD;
      OP_RUN:     return ST_RUN;
      default:    return ST_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/nco_cmd_sequencer_if.sv
// Valid/ready gate-command stream from the pulse controller into the NCO sequencer.
interface nco_cmd_sequencer_if;
  import nco_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  op_e                  cmd_op;
  logic [CMD_N-1:0]     cmd_data;
  logic [CMD_DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_dur, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_dur, output cmd_ready);
endinterface

// File: rtl/nco_cmd_sequencer_fifo.sv
// First-word-fall-through command buffer with registered empty/not-full flags.
module nco_cmd_fifo
  import nco_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t head,
  output logic empty,
  output logic not_full,
  output logic empty_nxt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          not_full_q, not_full_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push    = push && not_full_q;
    do_pop     = pop && !empty_q;
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_d    = (count_d == '0);
    not_full_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      not_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      not_full_q <= not_full_d;
    end
  end

  // Storage is data only; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head      = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign not_full  = not_full_q;
  assign empty_nxt = empty_d;

endmodule

// File: rtl/nco_cmd_sequencer.sv
// NCO command sequencer: buffers gate commands and drives NCO ftw/z_corr/phase writes cycle-exactly.
// Build option NCO_SEQ_FREE_RUN_EN keeps the phase accumulating in IDLE, FTW and VZ_LOAD.
module nco_cmd_sequencer
  import nco_pkg::*;
#(
  parameter int N            = CMD_N,
  parameter int Z_CORR_WIDTH = CMD_Z_W,
  parameter int DUR_WIDTH    = CMD_DUR_W,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  nco_cmd_sequencer_if.slave      cmd,
  output logic                    ftw_wr_en,
  output logic [N-1:0]            ftw_out,
  output logic                    z_corr_wr_en,
  output logic [Z_CORR_WIDTH-1:0] z_corr_out,
  output logic                    phase_wr_en,
  output logic                    z_corr_mode,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [DUR_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    last, pop, push;
  cmd_t                    head, din;
  logic                    fifo_empty, fifo_not_full, fifo_empty_nxt;

  logic                    ftw_wr_en_q, ftw_wr_en_d;
  logic [N-1:0]            ftw_out_q, ftw_out_d;
  logic                    z_corr_wr_en_q, z_corr_wr_en_d;
  logic [Z_CORR_WIDTH-1:0] z_corr_out_q, z_corr_out_d;
  logic                    phase_wr_en_q, phase_wr_en_d;
  logic                    z_corr_mode_q, z_corr_mode_d;
  logic                    busy_q, busy_d;

  assign push          = cmd.cmd_valid && fifo_not_full;
  assign cmd.cmd_ready = fifo_not_full;
  assign din           = '{op: cmd.cmd_op, data: cmd.cmd_data, dur: cmd.cmd_dur};

  nco_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .not_full  (fifo_not_full),
    .empty_nxt (fifo_empty_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ftw_wr_en_q    <= 1'b0;
      ftw_out_q      <= '0;
      z_corr_wr_en_q <= 1'b0;
      z_corr_out_q   <= '0;
      phase_wr_en_q  <= 1'b0;
      z_corr_mode_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ftw_wr_en_q    <= ftw_wr_en_d;
      ftw_out_q      <= ftw_out_d;
      z_corr_wr_en_q <= z_corr_wr_en_d;
      z_corr_out_q   <= z_corr_out_d;
      phase_wr_en_q  <= phase_wr_en_d;
      z_corr_mode_q  <= z_corr_mode_d;
      busy_q         <= busy_d;
    end
  end

  // Every state's final cycle dispatches the next head, so commands run with no bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE, ST_FTW, ST_VZ_APPLY: last = 1'b1;
      ST_VZ_LOAD:                   state_d = ST_VZ_APPLY;
      ST_RUN, ST_HOLD: begin
        if (cnt_q == '0) last = 1'b1;
        else             cnt_d = cnt_q - DUR_WIDTH'(1);
      end
      default:                      state_d = ST_IDLE;
    endcase
    if (last) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = op_to_state(head.op);
        cnt_d   = dur_last(head.dur);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Outputs are decoded from the next state so the registered ports line up with state_q.
  always_comb begin
    ftw_wr_en_d    = (state_d == ST_FTW);
    ftw_out_d      = (state_d == ST_FTW) ? head.data : ftw_out_q;
    z_corr_wr_en_d = (state_d == ST_VZ_LOAD) || (state_d == ST_VZ_APPLY);
    z_corr_out_d   = (state_d == ST_VZ_LOAD) ? head.data[Z_CORR_WIDTH-1:0] : '0;
    z_corr_mode_d  = (state_d == ST_VZ_APPLY);
`ifdef NCO_SEQ_FREE_RUN_EN
    phase_wr_en_d  = (state_d != ST_HOLD);
`else
    phase_wr_en_d  = (state_d == ST_RUN) || (state_d == ST_VZ_APPLY);
`endif
    busy_d         = (state_d != ST_IDLE) || !fifo_empty_nxt;
  end

  assign ftw_wr_en    = ftw_wr_en_q;
  assign ftw_out      = ftw_out_q;
  assign z_corr_wr_en = z_corr_wr_en_q;
  assign z_corr_out   = z_corr_out_q;
  assign phase_wr_en  = phase_wr_en_q;
  assign z_corr_mode  = z_corr_mode_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nco_cmd_sequencer.sv
// Bench for nco_cmd_sequencer: single-command table, corner sequences, and a randomized timed model.
module tb_nco_cmd_sequencer;
  import nco_pkg::*;

  localparam int N  = 22;
  localparam int ZW = 12;
  localparam int DW = 16;
  localparam int PW = PHASE_WIDTH;
`ifdef NCO_SEQ_FREE_RUN_EN
  localparam bit FR = 1'b1;
`else
  localparam bit FR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_cmd_sequencer_if cmd_if();

  logic          ftw_wr_en, z_corr_wr_en, phase_wr_en, z_corr_mode, busy;
  logic [N-1:0]  ftw_out;
  logic [ZW-1:0] z_corr_out;

  nco_cmd_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if),
    .ftw_wr_en    (ftw_wr_en),
    .ftw_out      (ftw_out),
    .z_corr_wr_en (z_corr_wr_en),
    .z_corr_out   (z_corr_out),
    .phase_wr_en  (phase_wr_en),
    .z_corr_mode  (z_corr_mode),
    .busy         (busy)
  );

  // Behavioural NCO: phase += (mode ? 0 : ftw) + z_corr on each phase write.
  logic [PW-1:0] nco_phase;
  logic [N-1:0]  nco_ftw;
  logic [ZW-1:0] nco_z;
  always @(posedge clk) begin
    if (rst) begin
      nco_phase <= '0;
      nco_ftw   <= '0;
      nco_z     <= '0;
    end else begin
      if (phase_wr_en)
        nco_phase <= nco_phase + (z_corr_mode ? {PW{1'b0}} : PW'(nco_ftw)) + PW'(nco_z);
      if (ftw_wr_en)    nco_ftw <= ftw_out;
      if (z_corr_wr_en) nco_z   <= z_corr_out;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mkp(input bit fw, input bit zw, input bit m, input bit ph,
                                      input logic [ZW-1:0] zo);
    return {fw, zw, m, ph, zo};
  endfunction

  function automatic logic [15:0] outs16();
    return {ftw_wr_en, z_corr_wr_en, z_corr_mode, phase_wr_en, z_corr_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns in the cycle after acceptance; the command's first output cycle follows.
  task automatic push(input op_e op, input logic [N-1:0] d, input logic [DW-1:0] du);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_dur   = du;
    while (!cmd_if.cmd_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  typedef struct {
    op_e          op;
    logic [N-1:0] data;
    logic [DW-1:0] dur;
    int           len;
    logic [15:0]  p0;
    logic [15:0]  pn;
    logic [N-1:0] ftw;
  } vec_t;

  vec_t tbl [10];

  bit           sl_act [0:4095];
  logic [15:0]  sl_pat [0:4095];
  logic [N-1:0] sl_ftw [0:4095];
  int           pop_at [0:4095];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_SET_FTW;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_dur   = '0;

    tbl[0] = '{OP_SET_FTW, 22'h001000, 16'd0, 1, mkp(1,0,0,FR,12'h0),   mkp(1,0,0,FR,12'h0), 22'h001000};
    tbl[1] = '{OP_RUN,     22'h000000, 16'd4, 4, mkp(0,0,0,1,12'h0),    mkp(0,0,0,1,12'h0),  22'h001000};
    tbl[2] = '{OP_RUN,     22'h000000, 16'd0, 1, mkp(0,0,0,1,12'h0),    mkp(0,0,0,1,12'h0),  22'h001000};
    tbl[3] = '{OP_HOLD,    22'h000000, 16'd0, 1, mkp(0,0,0,0,12'h0),    mkp(0,0,0,0,12'h0),  22'h001000};
    tbl[4] = '{OP_HOLD,    22'h000000, 16'd3, 3, mkp(0,0,0,0,12'h0),    mkp(0,0,0,0,12'h0),  22'h001000};
    tbl[5] = '{OP_VZ,      22'h000800, 16'd0, 2, mkp(0,1,0,FR,12'h800), mkp(0,1,1,1,12'h0),  22'h001000};
    tbl[6] = '{OP_SET_FTW, 22'h3FFFFF, 16'd9, 1, mkp(1,0,0,FR,12'h0),   mkp(1,0,0,FR,12'h0), 22'h3FFFFF};
    tbl[7] = '{OP_VZ,      22'h3FF123, 16'd5, 2, mkp(0,1,0,FR,12'h123), mkp(0,1,1,1,12'h0),  22'h3FFFFF};
    tbl[8] = '{OP_RUN,     22'h000000, 16'd1, 1, mkp(0,0,0,1,12'h0),    mkp(0,0,0,1,12'h0),  22'h3FFFFF};
    tbl[9] = '{OP_SET_FTW, 22'h000000, 16'd0, 1, mkp(1,0,0,FR,12'h0),   mkp(1,0,0,FR,12'h0), 22'h000000};

    // Reset state.
    do_reset();
    chk("reset_state", 64'({cmd_if.cmd_ready, busy, outs16(), ftw_out}), 64'({1'b1, 1'b0, 16'h0, 22'h0}));

    // Single commands from idle.
    for (int i = 0; i < 10; i++) begin
      push(tbl[i].op, tbl[i].data, tbl[i].dur);
      tick();
      for (int k = 0; k < tbl[i].len; k++) begin
        chk($sformatf("tbl%0d_cyc%0d", i, k), 64'({busy, outs16(), ftw_out}),
            64'({1'b1, (k == 0) ? tbl[i].p0 : tbl[i].pn, tbl[i].ftw}));
        tick();
      end
      chk($sformatf("tbl%0d_idle", i), 64'({busy, outs16(), ftw_out}),
          64'({1'b0, mkp(0,0,0,FR,12'h0), tbl[i].ftw}));
    end

    // Virtual-Z on the NCO with ftw=0: phase moves by exactly the angle, z_corr ends at 0.
    begin
      logic [PW-1:0] p0;
      tick();
      p0 = nco_phase;
      push(OP_VZ, 22'h000800, 16'd0);
      repeat (4) tick();
      chk("vz_nco_phase", 64'(nco_phase), 64'(p0 + PW'(24'h000800)));
      chk("vz_nco_zcorr", 64'(nco_z), 64'h0);
    end

    // SET_FTW then RUN 4 back-to-back.
    push(OP_SET_FTW, 22'h001000, 16'd0);
    push(OP_RUN, 22'h0, 16'd4);
    chk("b2b_ftw", 64'({ftw_wr_en, phase_wr_en, ftw_out}), 64'({1'b1, FR, 22'h001000}));
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_run%0d", k), 64'({ftw_wr_en, phase_wr_en}), 64'({1'b0, 1'b1}));
      tick();
    end
    chk("b2b_after", 64'({busy, phase_wr_en}), 64'({1'b0, FR}));

    // Buffer full during a long RUN, order preserved, zero-bubble drain.
    begin
      int acc = 0;
      int first_c = -1;
      int last_c = -1;
      logic [N-1:0] got[$];
      push(OP_RUN, 22'h0, 16'd100);
      tick();
      for (int c = 0; c < 300; c++) begin
        if (ftw_wr_en) begin
          got.push_back(ftw_out);
          if (first_c < 0) first_c = c;
          last_c = c;
        end
        if (c == 20) begin
          chk("fifo_accepted", 64'(acc), 64'd4);
          chk("fifo_ready_low", 64'(cmd_if.cmd_ready), 64'd0);
        end
        if (acc < 5) begin
          cmd_if.cmd_valid = 1'b1;
          cmd_if.cmd_op    = OP_SET_FTW;
          cmd_if.cmd_data  = N'(acc + 1);
          cmd_if.cmd_dur   = '0;
          if (cmd_if.cmd_ready) acc++;
        end else begin
          cmd_if.cmd_valid = 1'b0;
        end
        tick();
      end
      cmd_if.cmd_valid = 1'b0;
      chk("fifo_pulses", 64'(got.size()), 64'd5);
      for (int i = 0; i < got.size(); i++) chk($sformatf("fifo_order%0d", i), 64'(got[i]), 64'(i + 1));
      chk("fifo_no_bubble", 64'(last_c - first_c), 64'd4);
    end

    // Reset in the middle of RUN 50 with two queued commands.
    begin
      int act = 0;
      push(OP_RUN, 22'h0, 16'd50);
      tick();
      push(OP_SET_FTW, 22'h0000AA, 16'd0);
      push(OP_SET_FTW, 22'h0000BB, 16'd0);
      repeat (7) tick();
      chk("midrun_running", 64'(phase_wr_en), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrun_reset", 64'({cmd_if.cmd_ready, busy, outs16(), ftw_out}), 64'({1'b1, 1'b0, 16'h0, 22'h0}));
      for (int k = 0; k < 20; k++) begin
        act += int'(ftw_wr_en) + int'(z_corr_wr_en) + int'(busy) + (FR ? 0 : int'(phase_wr_en));
        tick();
      end
      chk("midrun_quiet", 64'(act), 64'd0);
    end

    // Idle accumulation with ftw=0x10: free-running build advances 8*0x10 in 8 cycles.
    begin
      logic [PW-1:0] p0;
      push(OP_SET_FTW, 22'h000010, 16'd0);
      repeat (3) tick();
      p0 = nco_phase;
      repeat (8) tick();
      chk("idle_phase", 64'(nco_phase), 64'(p0 + (FR ? PW'(24'h80) : PW'(0))));
    end

    // Randomized traffic against a timed command model.
    begin
      int count = 0;
      int next_free = 0;
      logic [N-1:0] last_ftw = '0;
      for (int i = 0; i < 4096; i++) begin
        sl_act[i] = 1'b0;
        sl_pat[i] = '0;
        sl_ftw[i] = '0;
        pop_at[i] = 0;
      end
      do_reset();
      for (int c = 0; c < 1400; c++) begin
        logic [15:0] ep;
        bit er, eb, accf;
        op_e op;
        logic [N-1:0] d;
        logic [DW-1:0] du;
        int len, st;
        er = (count < 4);
        ep = sl_act[c] ? sl_pat[c] : mkp(0,0,0,FR,12'h0);
        if (sl_act[c] && sl_pat[c][15]) last_ftw = sl_ftw[c];
        eb = sl_act[c] || (count != 0);
        if (c > 0)
          chk($sformatf("rand_cyc%0d", c), 64'({cmd_if.cmd_ready, busy, outs16(), ftw_out}),
              64'({er, eb, ep, last_ftw}));
        accf = 1'b0;
        if (c < 1200 && $urandom_range(0, 99) < 60) begin
          op = op_e'($urandom_range(0, 3));
          d  = N'($urandom);
          du = DW'($urandom_range(0, 6));
          if ($urandom_range(0, 9) == 0) du = DW'($urandom_range(7, 20));
          cmd_if.cmd_valid = 1'b1;
          cmd_if.cmd_op    = op;
          cmd_if.cmd_data  = d;
          cmd_if.cmd_dur   = du;
          if (er) begin
            accf = 1'b1;
            len = (op == OP_SET_FTW) ? 1 : (op == OP_VZ) ? 2 : ((du == 0) ? 1 : int'(du));
            st  = (c + 2 > next_free) ? c + 2 : next_free;
            for (int k = 0; k < len; k++) begin
              sl_act[st+k] = 1'b1;
              sl_ftw[st+k] = d;
              case (op)
                OP_SET_FTW: sl_pat[st+k] = mkp(1,0,0,FR,12'h0);
                OP_VZ:      sl_pat[st+k] = (k == 0) ? mkp(0,1,0,FR,d[ZW-1:0]) : mkp(0,1,1,1,12'h0);
                OP_RUN:     sl_pat[st+k] = mkp(0,0,0,1,12'h0);
                default:    sl_pat[st+k] = mkp(0,0,0,0,12'h0);
              endcase
            end
            pop_at[st-1]++;
            next_free = st + len;
          end
        end else begin
          cmd_if.cmd_valid = 1'b0;
        end
        tick();
        count = count + int'(accf) - pop_at[c];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
